// File: rtl/dfd_cla_action_sequencer.sv
// dfd_cla_action_sequencer
//   Consumer end of the CLA event bus. Evaluates the event/action pairs (EAPs)
//   of the current trigger node against event_bus every cycle. It drives
//   counter strobes and levels, cross-trigger pulses and the trace enable.
//   It advances the node on the winning (lowest-index) EAP match.
//
// Ports
//   clock, reset     : block clock, asynchronous active-high reset
//   cla_enable       : run enable; low holds node 0 with idle outputs
//   event_bus        : generator events (bit 1 always-on, bit 0 never-on)
//   eap_cfg          : EAP config words, word index = node*NUM_EAPS + eap
//   counter_inc/clr  : one-cycle increment / clear strobes per counter
//   counter_auto_en  : per-counter auto-increment level
//   xtrigger_out     : one-cycle cross-trigger pulses
//   trace_en         : trace capture enable level
//   current_node     : present sequencer node
//   eap_fired        : per-EAP match registered from the node just evaluated
module dfd_cla_action_sequencer #(
  parameter int unsigned NUM_EVENTS     = 64,
  parameter int unsigned NUM_NODES      = 4,
  parameter int unsigned NUM_EAPS       = 2,
  parameter int unsigned NUM_COUNTERS   = 2,
  parameter int unsigned XTRIGGER_WIDTH = 2,
  parameter int unsigned EAP_CFG_W      = 24
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    cla_enable,
  input  logic [NUM_EVENTS-1:0]                   event_bus,
  input  logic [NUM_NODES*NUM_EAPS*EAP_CFG_W-1:0] eap_cfg,
  output logic [NUM_COUNTERS-1:0]                 counter_inc,
  output logic [NUM_COUNTERS-1:0]                 counter_clr,
  output logic [NUM_COUNTERS-1:0]                 counter_auto_en,
  output logic [XTRIGGER_WIDTH-1:0]               xtrigger_out,
  output logic                                    trace_en,
  output logic [1:0]                              current_node,
  output logic [NUM_EAPS-1:0]                     eap_fired
);

  localparam int unsigned SEL_W  = $clog2(NUM_EVENTS);
  localparam int unsigned F_SA   = 1;
  localparam int unsigned F_SB   = F_SA + SEL_W;
  localparam int unsigned F_OP   = F_SB + SEL_W;
  localparam int unsigned F_NEXT = F_OP + 2;
  localparam int unsigned F_ACT  = F_NEXT + 2;
  localparam int unsigned F_ARG  = F_ACT + 4;

  typedef enum logic [1:0] {
    OP_A    = 2'd0,
    OP_AND  = 2'd1,
    OP_OR   = 2'd2,
    OP_ANDN = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    ACT_NONE      = 4'd0,
    ACT_INC       = 4'd1,
    ACT_CLR       = 4'd2,
    ACT_AUTO_ON   = 4'd3,
    ACT_AUTO_OFF  = 4'd4,
    ACT_XTRIG     = 4'd5,
    ACT_TRACE_ON  = 4'd6,
    ACT_TRACE_OFF = 4'd7
  } act_e;

  logic [1:0]                node_q, node_d;
  logic [NUM_COUNTERS-1:0]   inc_q, inc_d;
  logic [NUM_COUNTERS-1:0]   clr_q, clr_d;
  logic [NUM_COUNTERS-1:0]   auto_q, auto_d;
  logic [XTRIGGER_WIDTH-1:0] xtrig_q, xtrig_d;
  logic                      trace_q, trace_d;
  logic [NUM_EAPS-1:0]       fired_q, fired_d;

  logic [31:0]               base;
  logic [SEL_W-1:0]          sel_a, sel_b;
  logic                      ev_a, ev_b, match, hit, won;
  logic [1:0]                next_node;
  logic [31:0]               arg_idx;
  logic [NUM_COUNTERS-1:0]   cnt_sel;
  logic [XTRIGGER_WIDTH-1:0] xt_sel;
  logic [NUM_COUNTERS-1:0]   inc_req, clr_req, auto_on, auto_off;
  logic [XTRIGGER_WIDTH-1:0] xt_req;
  logic                      trace_on, trace_off;

  always_comb begin
    base      = '0;
    sel_a     = '0;
    sel_b     = '0;
    ev_a      = 1'b0;
    ev_b      = 1'b0;
    match     = 1'b0;
    hit       = 1'b0;
    won       = 1'b0;
    next_node = '0;
    arg_idx   = '0;
    cnt_sel   = '0;
    xt_sel    = '0;
    inc_req   = '0;
    clr_req   = '0;
    auto_on   = '0;
    auto_off  = '0;
    xt_req    = '0;
    trace_on  = 1'b0;
    trace_off = 1'b0;
    node_d    = node_q;
    fired_d   = '0;

    for (int unsigned k = 0; k < NUM_EAPS; k++) begin
      base  = (32'(node_q) * NUM_EAPS + k) * EAP_CFG_W;
      sel_a = eap_cfg[base + F_SA +: SEL_W];
      sel_b = eap_cfg[base + F_SB +: SEL_W];
      ev_a  = event_bus[sel_a];
      ev_b  = event_bus[sel_b];
      case (op_e'(eap_cfg[base + F_OP +: 2]))
        OP_A:    match = ev_a;
        OP_AND:  match = ev_a & ev_b;
        OP_OR:   match = ev_a | ev_b;
        default: match = ev_a & ~ev_b;
      endcase
      hit        = eap_cfg[base] & match;
      fired_d[k] = hit;

      // Only the first hit picks the node; out-of-range targets hold it.
      next_node = eap_cfg[base + F_NEXT +: 2];
      if (hit && !won) begin
        won = 1'b1;
        if (32'(next_node) < NUM_NODES) begin
          node_d = next_node;
        end
      end

      // Out-of-range arg decodes to an all-zero select, i.e. a no-op.
      arg_idx = 32'(eap_cfg[base + F_ARG +: 2]);
      for (int unsigned c = 0; c < NUM_COUNTERS; c++) begin
        cnt_sel[c] = (arg_idx == c);
      end
      for (int unsigned x = 0; x < XTRIGGER_WIDTH; x++) begin
        xt_sel[x] = (arg_idx == x);
      end

      if (hit) begin
        case (act_e'(eap_cfg[base + F_ACT +: 4]))
          ACT_INC:       inc_req  = inc_req  | cnt_sel;
          ACT_CLR:       clr_req  = clr_req  | cnt_sel;
          ACT_AUTO_ON:   auto_on  = auto_on  | cnt_sel;
          ACT_AUTO_OFF:  auto_off = auto_off | cnt_sel;
          ACT_XTRIG:     xt_req   = xt_req   | xt_sel;
          ACT_TRACE_ON:  trace_on  = 1'b1;
          ACT_TRACE_OFF: trace_off = 1'b1;
          default:       ;
        endcase
      end
    end

    // Conflict resolution: clear, disable and stop win over their opposites.
    inc_d   = inc_req & ~clr_req;
    clr_d   = clr_req;
    auto_d  = (auto_q | auto_on) & ~auto_off;
    xtrig_d = xt_req;
    trace_d = (trace_q | trace_on) & ~trace_off;

    if (!cla_enable) begin
      node_d  = '0;
      inc_d   = '0;
      clr_d   = '0;
      auto_d  = '0;
      xtrig_d = '0;
      trace_d = 1'b0;
      fired_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      node_q  <= '0;
      inc_q   <= '0;
      clr_q   <= '0;
      auto_q  <= '0;
      xtrig_q <= '0;
      trace_q <= 1'b0;
      fired_q <= '0;
    end else begin
      node_q  <= node_d;
      inc_q   <= inc_d;
      clr_q   <= clr_d;
      auto_q  <= auto_d;
      xtrig_q <= xtrig_d;
      trace_q <= trace_d;
      fired_q <= fired_d;
    end
  end

  assign current_node    = node_q;
  assign counter_inc     = inc_q;
  assign counter_clr     = clr_q;
  assign counter_auto_en = auto_q;
  assign xtrigger_out    = xtrig_q;
  assign trace_en        = trace_q;
  assign eap_fired       = fired_q;

endmodule

// File: tb/tb_dfd_cla_action_sequencer.sv
// Testbench for dfd_cla_action_sequencer: directed vector table, hand-written
// reset / node-hold sequences, and randomized stimulus against a reference model.
module tb_dfd_cla_action_sequencer;

  localparam int CFG_W  = 4 * 2 * 24;
  localparam int CFG3_W = 3 * 2 * 24;
  localparam int NN     = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              en    = 1'b0;
  logic              en3   = 1'b0;
  logic [63:0]       ev    = 64'h2;
  logic [CFG_W-1:0]  cfg   = '0;
  logic [CFG3_W-1:0] cfg3  = '0;

  logic [1:0] inc, clr, aut, xt, node, fired;
  logic       tr;
  logic [1:0] inc3, clr3, aut3, xt3, node3, fired3;
  logic       tr3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dfd_cla_action_sequencer u_dut (
    .clock(clock), .reset(reset), .cla_enable(en), .event_bus(ev), .eap_cfg(cfg),
    .counter_inc(inc), .counter_clr(clr), .counter_auto_en(aut),
    .xtrigger_out(xt), .trace_en(tr), .current_node(node), .eap_fired(fired)
  );

  dfd_cla_action_sequencer #(.NUM_NODES(3)) u_dut3 (
    .clock(clock), .reset(reset), .cla_enable(en3), .event_bus(ev), .eap_cfg(cfg3),
    .counter_inc(inc3), .counter_clr(clr3), .counter_auto_en(aut3),
    .xtrigger_out(xt3), .trace_en(tr3), .current_node(node3), .eap_fired(fired3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_inc, input logic [1:0] e_clr,
                           input logic [1:0] e_aut, input logic [1:0] e_xt, input logic e_tr,
                           input logic [1:0] e_node, input logic [1:0] e_fired);
    check({tag, ".inc"},   64'(inc),   64'(e_inc));
    check({tag, ".clr"},   64'(clr),   64'(e_clr));
    check({tag, ".auto"},  64'(aut),   64'(e_aut));
    check({tag, ".xtrig"}, 64'(xt),    64'(e_xt));
    check({tag, ".trace"}, 64'(tr),    64'(e_tr));
    check({tag, ".node"},  64'(node),  64'(e_node));
    check({tag, ".fired"}, 64'(fired), 64'(e_fired));
  endtask

  function automatic logic [23:0] eap(input int e, input int sa, input int sb, input int op,
                                      input int nn, input int act, input int arg);
    logic [23:0] w;
    w        = '0;
    w[0]     = e[0];
    w[6:1]   = sa[5:0];
    w[12:7]  = sb[5:0];
    w[14:13] = op[1:0];
    w[16:15] = nn[1:0];
    w[20:17] = act[3:0];
    w[22:21] = arg[1:0];
    return w;
  endfunction

  function automatic logic [CFG_W-1:0] put(input logic [CFG_W-1:0] c, input int nd, input int k,
                                           input logic [23:0] w);
    c[(nd*2+k)*24 +: 24] = w;
    return c;
  endfunction

  function automatic logic [63:0] B(input int n);
    return 64'd1 << n;
  endfunction

  typedef struct {
    logic             en;
    logic [63:0]      ev;
    logic [CFG_W-1:0] cfg;
    logic [1:0]       inc, clr, aut, xt;
    logic             tr;
    logic [1:0]       node, fired;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic [63:0] v, input logic [CFG_W-1:0] c,
                     input logic [1:0] i, input logic [1:0] cl, input logic [1:0] a,
                     input logic [1:0] x, input logic t, input logic [1:0] n, input logic [1:0] f);
    vec_t r;
    r.en = e; r.ev = v; r.cfg = c;
    r.inc = i; r.clr = cl; r.aut = a; r.xt = x; r.tr = t; r.node = n; r.fired = f;
    vecs.push_back(r);
  endtask

  // Reference model: node, auto levels and trace level held as plain state.
  int         m_node;
  logic [1:0] m_auto;
  logic       m_trace;
  logic [1:0] x_inc, x_clr, x_xt, x_fired;

  task automatic model_step(input logic e, input logic [63:0] v, input logic [CFG_W-1:0] c);
    int inc_n[2], clr_n[2], on_n[2], off_n[2], xt_n[2];
    int t_on, t_off, won, nxt, arg;
    logic [23:0] w;
    logic a, b, hit;
    x_inc = '0; x_clr = '0; x_xt = '0; x_fired = '0;
    if (!e) begin
      m_node = 0; m_auto = '0; m_trace = 1'b0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      inc_n[i] = 0; clr_n[i] = 0; on_n[i] = 0; off_n[i] = 0; xt_n[i] = 0;
    end
    t_on = 0; t_off = 0; won = 0; nxt = m_node;
    for (int k = 0; k < 2; k++) begin
      w = c[(m_node*2+k)*24 +: 24];
      a = v[w[6:1]];
      b = v[w[12:7]];
      case (w[14:13])
        2'd0:    hit = a;
        2'd1:    hit = a && b;
        2'd2:    hit = a || b;
        default: hit = a && !b;
      endcase
      if (w[0] && hit) begin
        x_fired[k] = 1'b1;
        if (won == 0) begin
          won = 1;
          if (int'(w[16:15]) < NN) nxt = int'(w[16:15]);
        end
        arg = int'(w[22:21]);
        if (arg < 2) begin
          case (int'(w[20:17]))
            1: inc_n[arg]++;
            2: clr_n[arg]++;
            3: on_n[arg]++;
            4: off_n[arg]++;
            5: xt_n[arg]++;
            default: ;
          endcase
        end
        if (int'(w[20:17]) == 6) t_on++;
        if (int'(w[20:17]) == 7) t_off++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      x_clr[i] = clr_n[i] > 0;
      x_inc[i] = inc_n[i] > 0 && clr_n[i] == 0;
      x_xt[i]  = xt_n[i] > 0;
      if (off_n[i] > 0)     m_auto[i] = 1'b0;
      else if (on_n[i] > 0) m_auto[i] = 1'b1;
    end
    if (t_off > 0)     m_trace = 1'b0;
    else if (t_on > 0) m_trace = 1'b1;
    m_node = nxt;
  endtask

  function automatic logic [23:0] rand_eap();
    logic [23:0] w;
    w = eap(($urandom_range(0, 4) != 0) ? 1 : 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    w[23] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [CFG_W-1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8;
    logic [63:0] EV1;
    EV1 = 64'h2;

    // Reset state, checked before any clock edge.
    #1 reset = 1'b1;
    #1 check_all("reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    c0 = put('0, 0, 0, eap(1, 1, 0, 0, 1, 5, 1));
    c1 = put(put('0, 0, 0, eap(1, 5, 0, 0, 0, 1, 0)), 0, 1, eap(1, 5, 0, 0, 3, 2, 0));
    c2 = put('0, 0, 0, eap(1, 1, 0, 0, 0, 1, 3));
    c3 = put('0, 0, 0, eap(1, 8, 9, 3, 2, 1, 1));
    c4 = put(put('0, 0, 0, eap(1, 1, 0, 0, 1, 6, 0)), 1, 0, eap(1, 10, 0, 0, 1, 7, 0));
    c5 = put(put('0, 0, 0, eap(1, 1, 0, 0, 0, 6, 0)), 0, 1, eap(1, 1, 0, 0, 0, 7, 0));
    c6 = put(put('0, 0, 0, eap(1, 1, 0, 0, 0, 3, 0)), 0, 1, eap(1, 12, 0, 0, 0, 4, 0));
    c7 = put(put('0, 0, 0, eap(1, 1, 13, 1, 2, 1, 1)), 0, 1, eap(1, 0, 14, 2, 3, 1, 1));
    c8 = put('0, 0, 0, eap(0, 1, 0, 0, 1, 5, 0));

    //  en  event bus             cfg  inc    clr    auto   xtrig  tr    node  fired
    add(1, EV1,                   c0, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 2'd1, 2'b01);
    add(1, EV1,                   c0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd1, 2'b00);
    add(0, EV1,                   c0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);
    add(1, EV1 | B(5),            c1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 2'd0, 2'b11);
    add(1, EV1,                   c1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);
    add(1, EV1,                   c2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b01);
    add(1, EV1 | B(8) | B(9),     c3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);
    add(1, EV1 | B(8),            c3, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'd2, 2'b01);
    add(0, EV1,                   c3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);
    add(1, EV1,                   c4, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'd1, 2'b01);
    add(1, EV1,                   c4, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'd1, 2'b00);
    add(1, EV1,                   c4, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'd1, 2'b00);
    add(1, EV1 | B(10),           c4, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd1, 2'b01);
    add(0, EV1,                   c4, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);
    add(1, EV1,                   c5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b11);
    add(1, EV1,                   c6, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 2'd0, 2'b01);
    add(1, EV1,                   c6, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 2'd0, 2'b01);
    add(1, EV1 | B(12),           c6, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b11);
    add(1, EV1 | B(13) | B(14),   c7, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'd2, 2'b11);
    add(0, EV1,                   c7, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);
    add(1, EV1 | B(14),           c7, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'd3, 2'b10);
    add(0, EV1,                   c7, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);
    add(1, EV1,                   c8, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);
    add(0, EV1,                   c8, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);

    foreach (vecs[i]) begin
      en = vecs[i].en; ev = vecs[i].ev; cfg = vecs[i].cfg;
      @(posedge clock); #1;
      check_all($sformatf("vec%0d", i), vecs[i].inc, vecs[i].clr, vecs[i].aut, vecs[i].xt,
                vecs[i].tr, vecs[i].node, vecs[i].fired);
    end

    // Asynchronous reset in the middle of a run.
    cfg = put('0, 0, 0, eap(1, 1, 0, 0, 2, 6, 0));
    ev = EV1; en = 1'b1;
    @(posedge clock); #1;
    check_all("midrun.pre", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'd2, 2'b01);
    #2 reset = 1'b1;
    #1 check_all("midrun.async", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);
    en = 1'b0;
    #1 reset = 1'b0;
    #1 check("midrun.release.node", 64'(node), 64'd0);
    @(posedge clock); #1;
    check_all("midrun.post", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'b00);

    // Three-node instance: next_node 3 is out of range, node holds, action runs.
    cfg3 = '0;
    cfg3[23:0] = eap(1, 1, 0, 0, 3, 3, 1);
    en3 = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(posedge clock); #1;
      check($sformatf("hold%0d.node", n),  64'(node3),  64'd0);
      check($sformatf("hold%0d.auto", n),  64'(aut3),   64'b10);
      check($sformatf("hold%0d.fired", n), 64'(fired3), 64'b01);
    end
    cfg3[23:0] = '0;
    @(posedge clock); #1;
    check("hold.persist.auto", 64'(aut3), 64'b10);
    en3 = 1'b0;
    @(posedge clock); #1;
    check("hold.off.auto", 64'(aut3), 64'b00);
    check("hold.off.node", 64'(node3), 64'd0);

    // Randomized run against the reference model, with mid-run config edits.
    m_node = 0; m_auto = '0; m_trace = 1'b0;
    cfg = '0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg[$urandom_range(0, 7)*24 +: 24] = rand_eap();
      end
      en = ($urandom_range(0, 19) != 0);
      ev = {$urandom, $urandom};
      ev[1] = 1'b1;
      ev[0] = 1'b0;
      model_step(en, ev, cfg);
      @(posedge clock); #1;
      check_all($sformatf("rnd%0d", n), x_inc, x_clr, m_auto, x_xt, m_trace, 2'(m_node), x_fired);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dfd_cla_action_sequencer.md
Name: dfd_cla_action_sequencer

Overview:
- Consumer end of the CLA event bus: evaluates event/action pairs (EAPs) against the current node of a small trigger state machine.
- Produces the per-counter control strobes that the CLA counters consume, plus cross-trigger pulses and a trace-enable level.
- Sits between the event generators and the counters/trace sink inside the core logic analyzer; state is advanced only by configured EAP matches.

Parameters:
- NUM_EVENTS, 64, width of event_bus; event select fields are log2(NUM_EVENTS) bits.
- NUM_NODES, 4, number of sequencer nodes; node index is 2 bits.
- NUM_EAPS, 2, EAPs per node; a lower EAP index has higher priority.
- NUM_COUNTERS, 2, number of CLA counters driven.
- XTRIGGER_WIDTH, 2, number of cross-trigger outputs.
- EAP_CFG_W, 24, bits per EAP config word.

Ports:
- clock, input, 1, block clock.
- reset, input, 1, asynchronous active-high reset.
- cla_enable, input, 1, sequencer run enable; low forces node 0 and idle outputs.
- event_bus, input, NUM_EVENTS, events from generators; bit 1 is always-on, bit 0 is never-on.
- eap_cfg, input, NUM_NODES*NUM_EAPS*EAP_CFG_W, EAP config. Word index is node*NUM_EAPS+eap. Fields:
  - [0] enable
  - [6:1] sel_a
  - [12:7] sel_b
  - [14:13] op (0=A, 1=A&B, 2=A|B, 3=A&~B)
  - [16:15] next_node
  - [20:17] action
  - [22:21] arg
  - [23] reserved
- counter_inc, output, NUM_COUNTERS, one-cycle increment strobe per counter.
- counter_clr, output, NUM_COUNTERS, one-cycle clear strobe per counter.
- counter_auto_en, output, NUM_COUNTERS, level: counter auto-increments every cycle.
- xtrigger_out, output, XTRIGGER_WIDTH, one-cycle cross-trigger pulse.
- trace_en, output, 1, trace capture enable level.
- current_node, output, 2, present node.
- eap_fired, output, NUM_EAPS, registered per-EAP match in the node just left; debug visibility.

Behaviour:
- Reset: current_node=0 and trace_en=0; all other outputs 0 (every strobe, counter_auto_en, xtrigger_out, eap_fired).
- cla_enable=0: same state as reset, applied synchronously each cycle. The rising edge of cla_enable starts evaluation in node 0 on that cycle.
- Match: an EAP fires when enable=1 and op(event_bus[sel_a], event_bus[sel_b]) is 1. Only the EAPs of current_node are evaluated. event_bus is used combinationally, with no input register.
- Latency: every effect is registered. An event in cycle N gives strobes, level changes and the node change at the edge ending cycle N, so they are visible in cycle N+1.
- Transition:
  - The lowest-index fired EAP selects next_node.
  - No fire means the node holds.
  - next_node >= NUM_NODES means the node holds; its action still executes.
  - A self-transition is legal and re-fires every cycle the condition holds.
- Actions execute for every fired EAP, not only the winner. arg selects the counter or xtrigger index; an out-of-range arg makes the action a no-op.
  - 0: none
  - 1: counter_inc[arg]
  - 2: counter_clr[arg]
  - 3: counter_auto_en[arg]=1
  - 4: counter_auto_en[arg]=0
  - 5: xtrigger_out[arg] pulse
  - 6: trace_en=1
  - 7: trace_en=0
  - 8-15: none
- Conflicts in the same cycle, resolved in this order:
  - clr beats inc on the same counter; only clr asserts.
  - auto disable beats auto enable.
  - trace stop beats trace start.
  - Duplicate inc or xtrigger actions collapse into one strobe.
- Levels (counter_auto_en, trace_en) persist across node changes until an explicit action, cla_enable low, or reset.
- Strobes are exactly one cycle wide. Consecutive firing cycles give back-to-back strobes.
- A config change mid-run takes effect in the next evaluation cycle; there is no shadowing.
- eap_fired[k] is high for one cycle after EAP k fired.

Test Plan:
1. Reset mid-run: trace_en=1, current_node=2, then reset asserted asynchronously -> outputs go 0 immediately without a clock edge; after deassert current_node=0.
2. Node0 EAP0 {sel_a=1, op=A, next_node=1, action=5, arg=1} with cla_enable rising in cycle 0 -> xtrigger_out=2'b10 in cycle 1 only; current_node=1 from cycle 1.
3. Node0 EAP0 {sel_a=5, action=1, arg=0} and EAP1 {sel_a=5, action=2, arg=0, next_node=3}, event_bus[5]=1 -> counter_clr[0]=1, counter_inc[0]=0; EAP0 wins so current_node=0 (its next_node), not 3.
4. op=3 with sel_a=8, sel_b=9: event_bus[8]=1, event_bus[9]=1 -> no fire; event_bus[9]=0 -> fire next cycle.
5. Action 6 in node0 (next_node=1), then action 7 in node1 three cycles later -> trace_en high for exactly those cycles. Separately, actions 6 and 7 in the same cycle -> trace_en stays 0.
6. next_node=3 with NUM_NODES=3 and action=3, arg=1 -> node holds; counter_auto_en[1]=1 persists. Then cla_enable=0 -> counter_auto_en=0 and current_node=0 next cycle.
